// File: rtl/lc3b_types.sv
// Shared types for the branch-predictor table controller: FSM state,
// PHT counter constants and the 2-bit saturating counter update.
package lc3b_types;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_ctrl_state_t;

    localparam logic [1:0] BP_CTR_WEAK_NT = 2'b01;

    function automatic logic [1:0] bp_sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small power-of-two FIFO that buffers resolved-branch updates until the
// PHT write port is free. Storage is not reset; only pointers and count are.
module bp_update_fifo #(
    parameter int width = 6,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    rd_ptr;
    logic [aw-1:0]    wr_ptr;
    logic [aw:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (aw+1)'(depth));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + aw'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + aw'(1);
            if (push_ok && !pop_ok)      count <= count + (aw+1)'(1);
            else if (pop_ok && !push_ok) count <= count - (aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bp_table_ctrl.sv
// PHT controller: sweeps the table to weakly-not-taken after reset/flush, then
// applies buffered branch outcomes as saturating counter updates.
// Optional BP_UPDATE_BYPASS_EN writes an update in its acceptance cycle when the buffer is empty.
module bp_table_ctrl
    import lc3b_types::*;
#(
    parameter int index_bits = 5,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  upd_valid,
    input  logic [index_bits-1:0] upd_idx,
    input  logic                  upd_taken,
    output logic                  upd_ready,
    output logic [index_bits-1:0] pht_rindex,
    input  logic [1:0]            pht_rdata,
    output logic                  pht_write,
    output logic [index_bits-1:0] pht_windex,
    output logic [1:0]            pht_wdata,
    output logic                  pred_enable,
    output logic                  busy
);

    localparam int entry_w = index_bits + 1;

    bp_ctrl_state_t        state, state_next;
    logic [index_bits-1:0] sweep_cnt;
    logic                  accept, bypass, push, pop;
    logic                  fifo_full, fifo_empty;
    logic [entry_w-1:0]    head;

    assign upd_ready = !fifo_full && !flush && !reset;
    assign accept    = upd_valid && upd_ready;

`ifdef BP_UPDATE_BYPASS_EN
    assign bypass = accept && (state == RUN) && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;
    assign pop  = (state == RUN) && !fifo_empty && !flush && !reset;
    assign busy = (state == INIT) || !fifo_empty;

    bp_update_fifo #(
        .width (entry_w),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .clear (reset || flush),
        .push  (push),
        .pop   (pop),
        .din   ({upd_idx, upd_taken}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Writes are suppressed in a flush cycle so the restarted sweep begins cleanly at index 0.
    always_comb begin
        state_next = state;
        pht_write  = 1'b0;
        pht_rindex = head[entry_w-1:1];
        pht_windex = sweep_cnt;
        pht_wdata  = BP_CTR_WEAK_NT;
        case (state)
            INIT: begin
                pht_write = !flush && !reset;
                if (&sweep_cnt) state_next = RUN;
            end
            RUN: begin
                if (bypass) begin
                    pht_rindex = upd_idx;
                    pht_windex = upd_idx;
                    pht_wdata  = bp_sat_update(pht_rdata, upd_taken);
                    pht_write  = 1'b1;
                end else begin
                    pht_windex = head[entry_w-1:1];
                    pht_wdata  = bp_sat_update(pht_rdata, head[0]);
                    pht_write  = pop;
                end
            end
            default: state_next = INIT;
        endcase
        if (flush) state_next = INIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT;
            sweep_cnt   <= '0;
            pred_enable <= 1'b0;
        end else begin
            state       <= state_next;
            pred_enable <= (state_next == RUN);
            if (flush)               sweep_cnt <= '0;
            else if (state == INIT)  sweep_cnt <= sweep_cnt + index_bits'(1);
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl: modelled PHT array, write scoreboard,
// table-driven RUN updates plus sequences for sweep, INIT back-pressure and flush.
module tb_bp_table_ctrl;

    localparam int IB = 5;
    localparam int FD = 4;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset, flush, upd_valid, upd_taken;
    logic [IB-1:0] upd_idx;
    logic          upd_ready;
    logic [IB-1:0] pht_rindex, pht_windex;
    logic [1:0]    pht_rdata, pht_wdata;
    logic          pht_write, pred_enable, busy;

    logic [1:0] pht_mem [N] = '{default: 2'b00};
    logic [1:0] ref_ctr [N];

    typedef struct { logic [IB-1:0] idx; logic [1:0] exp; } wr_t;
    wr_t exp_q[$];

    typedef struct { logic [IB-1:0] idx; logic taken; logic [1:0] exp; } vec_t;
    vec_t vecs [11];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    bp_table_ctrl #(.index_bits(IB), .fifo_depth(FD)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_taken   (upd_taken),
        .upd_ready   (upd_ready),
        .pht_rindex  (pht_rindex),
        .pht_rdata   (pht_rdata),
        .pht_write   (pht_write),
        .pht_windex  (pht_windex),
        .pht_wdata   (pht_wdata),
        .pred_enable (pred_enable),
        .busy        (busy)
    );

    always_comb pht_rdata = pht_mem[pht_rindex];

    always @(posedge clk) begin
        if (pht_write === 1'b1) pht_mem[pht_windex] <= pht_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] tb_sat(input logic [1:0] c, input logic t);
        case ({c, t})
            3'b00_0: return 2'b00;
            3'b00_1: return 2'b01;
            3'b01_0: return 2'b00;
            3'b01_1: return 2'b10;
            3'b10_0: return 2'b01;
            3'b10_1: return 2'b11;
            3'b11_0: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Scoreboard: every observed PHT write must match the next expected one.
    always @(negedge clk) begin
        wr_t e;
        if (reset === 1'b0 && pht_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got idx %0d data %b expected no write at %0t",
                         pht_windex, pht_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("pht_write", {pht_windex, pht_wdata}, {e.idx, e.exp});
            end
        end
    end

    task automatic push_sweep();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back('{IB'(i), 2'b01});
            ref_ctr[i] = 2'b01;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic offer(input logic [IB-1:0] idx, input logic taken, input logic [1:0] exp,
                         output logic pe_at_accept);
        pe_at_accept = 1'bx;
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (upd_ready) begin
                exp_q.push_back('{idx, exp});
                ref_ctr[idx] = exp;
                pe_at_accept = pred_enable;
                @(posedge clk); #1;
                upd_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("offer_timeout", 32'd0, 32'd1);
        upd_valid = 1'b0;
    endtask

    task automatic offer_model(input logic [IB-1:0] idx, input logic taken, output logic pe);
        offer(idx, taken, tb_sat(ref_ctr[idx], taken), pe);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && exp_q.size() == 0) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic sweep_watch(input string name);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 32) check({name, "_pe_low_c32"}, pred_enable, 1'b0);
            if (k == 33) check({name, "_pe_high_c33"}, pred_enable, 1'b1);
        end
        check({name, "_all_writes"}, exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic pe;
        logic found;

        vecs[0]  = '{5'd5, 1'b1, 2'b10};
        vecs[1]  = '{5'd5, 1'b1, 2'b11};
        vecs[2]  = '{5'd5, 1'b1, 2'b11};
        vecs[3]  = '{5'd5, 1'b0, 2'b10};
        vecs[4]  = '{5'd7, 1'b0, 2'b00};
        vecs[5]  = '{5'd7, 1'b0, 2'b00};
        vecs[6]  = '{5'd7, 1'b1, 2'b01};
        vecs[7]  = '{5'd9, 1'b1, 2'b10};
        vecs[8]  = '{5'd9, 1'b0, 2'b01};
        vecs[9]  = '{5'd9, 1'b0, 2'b00};
        vecs[10] = '{5'd3, 1'b1, 2'b10};

        reset = 1'b1; flush = 1'b0;
        upd_valid = 1'b1; upd_idx = 5'd5; upd_taken = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_pht_write", pht_write, 1'b0);
        check("reset_upd_ready", upd_ready, 1'b0);
        check("reset_pred_enable", pred_enable, 1'b0);
        check("reset_busy", busy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0; upd_valid = 1'b0;
        push_sweep();
        sweep_watch("init_sweep");

        foreach (vecs[i]) offer(vecs[i].idx, vecs[i].taken, vecs[i].exp, pe);
        wait_idle("table_drain");

        // Not-taken on idx 3 (holds 10): write latency depends on the bypass build.
        upd_valid = 1'b1; upd_idx = 5'd3; upd_taken = 1'b0;
        #1;
        check("lat_ready", upd_ready, 1'b1);
        exp_q.push_back('{5'd3, 2'b01});
        @(negedge clk);
`ifdef BP_UPDATE_BYPASS_EN
        check("lat_accept_cycle_write", pht_write, 1'b1);
`else
        check("lat_accept_cycle_write", pht_write, 1'b0);
`endif
        @(posedge clk); #1;
        upd_valid = 1'b0;
        @(negedge clk);
`ifdef BP_UPDATE_BYPASS_EN
        check("lat_next_cycle_write", pht_write, 1'b0);
`else
        check("lat_next_cycle_write", pht_write, 1'b1);
`endif
        @(posedge clk); #1;
        check("lat_pht_value", pht_mem[3], 2'b01);

        // Flush together with an offered update: update must be refused.
        flush = 1'b1; upd_valid = 1'b1; upd_idx = 5'd12; upd_taken = 1'b1;
        #1;
        check("flush_upd_ready", upd_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; upd_valid = 1'b0;
        push_sweep();
        check("flush_pe_low", pred_enable, 1'b0);

        // Five updates during INIT with a 4-deep buffer.
        offer_model(5'd20, 1'b1, pe);
        offer_model(5'd21, 1'b0, pe);
        offer_model(5'd20, 1'b1, pe);
        offer_model(5'd22, 1'b1, pe);
        check("init_full_ready_low", upd_ready, 1'b0);
        check("init_full_pe_low", pred_enable, 1'b0);
        offer_model(5'd20, 1'b0, pe);
        check("fifth_accepted_in_run", pe, 1'b1);
        wait_idle("init_updates_drain");
        check("idx20_final", pht_mem[20], 2'b10);
        check("idx12_not_applied", pht_mem[12], 2'b01);

        // Flush at sweep_cnt 17 with two buffered updates.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        push_sweep();
        offer_model(5'd8, 1'b1, pe);
        offer_model(5'd9, 1'b0, pe);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (pht_write === 1'b1 && pht_windex == 5'd16) found = 1'b1;
        end
        check("reach_sweep_16", found, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        push_sweep();
        check("flush17_busy", busy, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        sweep_watch("resweep");
        wait_idle("resweep_drain");
        check("idx8_discarded", pht_mem[8], 2'b01);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
